convo_window_sched: RTL and testbench

//  Sequencer for the 3x3 line-buffer FIFO (ConvoFIFO) of the convolution engine.

---
 rtl/convo_window_sched.sv | 99 +++++++++
 tb/tb_convo_window_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/convo_window_sched.sv
// convo_window_sched: 3x3 line-buffer FIFO sequencer producing strided window positions per frame.
// Optional stall counter built when CONVO_SCHED_PERF_EN is defined.
module convo_window_sched #(
  parameter int ADDR_BIT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] row_len,
  input  logic [ADDR_BIT-1:0] img_rows,
  input  logic [2:0]          stride,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                fifo_wen,
  output logic                fifo_ren,
  output logic                fifo_clr,
  input  logic                fifo_load_done,
  input  logic                fifo_empty,
  input  logic                fifo_full,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [ADDR_BIT-1:0] win_row,
  output logic [ADDR_BIT-1:0] win_col,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [15:0]         perf_stall
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [ADDR_BIT-1:0] rl_q, rows_q;
  logic [2:0] stride_q;
  logic [2*ADDR_BIT-1:0] in_cnt, total;
  logic [ADDR_BIT+1:0] col_sum, row_sum;
  logic cfg_bad, col_wrap, row_last, wr_phase;
  assign cfg_bad  = (row_len < ADDR_BIT'(3)) || (img_rows < ADDR_BIT'(3));
  assign total    = (2*ADDR_BIT)'(rl_q) * (2*ADDR_BIT)'(rows_q);
  // Two extra bits keep position+stride+3 from wrapping before the compare.
  assign col_sum  = {2'b00, win_col} + (ADDR_BIT+2)'(stride_q) + (ADDR_BIT+2)'(3);
  assign row_sum  = {2'b00, win_row} + (ADDR_BIT+2)'(stride_q) + (ADDR_BIT+2)'(3);
  assign col_wrap = col_sum > {2'b00, rl_q};
  assign row_last = row_sum > {2'b00, rows_q};
  assign wr_phase  = (state == LOAD) || (state == RUN);
  assign s_ready   = wr_phase && !fifo_full && (in_cnt < total);
  assign fifo_wen  = s_valid && s_ready;
  assign win_valid = (state == RUN) && !fifo_empty;
  assign fifo_ren  = win_valid && win_ready;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign fifo_clr  = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rl_q     <= '0;
      rows_q   <= '0;
      stride_q <= '0;
      in_cnt   <= '0;
      win_row  <= '0;
      win_col  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (fifo_wen) in_cnt <= in_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          rl_q     <= row_len;
          rows_q   <= img_rows;
          stride_q <= (stride == 3'd0) ? 3'd1 : stride;
          in_cnt   <= '0;
          win_row  <= '0;
          win_col  <= '0;
          cfg_err  <= cfg_bad;
          state    <= cfg_bad ? DONE : LOAD;
        end
        LOAD: if (fifo_load_done) state <= RUN;
        RUN: if (fifo_ren) begin
          if (col_wrap) begin
            win_col <= '0;
            if (row_last) state <= DONE;
            else win_row <= win_row + ADDR_BIT'(stride_q);
          end else win_col <= win_col + ADDR_BIT'(stride_q);
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONVO_SCHED_PERF_EN
  logic [1:0]  perf_inc;
  logic [16:0] perf_sum;
  assign perf_inc = {1'b0, (state == RUN) && win_ready && fifo_empty} + {1'b0, wr_phase && s_valid && !s_ready};
  assign perf_sum = {1'b0, perf_stall} + 17'(perf_inc);
  always_ff @(posedge clk) begin
    if (rst) perf_stall <= '0;
    else if (state == IDLE && start) perf_stall <= '0;
    else perf_stall <= perf_sum[16] ? 16'hFFFF : perf_sum[15:0];
  end
`else
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_convo_window_sched.sv
// tb_convo_window_sched: randomized scoreboard bench; expected windows are enumerated per frame
// and popped by a monitor on every handshake.
module tb_convo_window_sched;
  logic clk = 0, rst = 1, start = 0;
  logic [4:0] row_len = 0, img_rows = 0;
  logic [2:0] stride = 0;
  logic s_valid = 0, fifo_load_done = 0, fifo_empty = 1, fifo_full = 0, win_ready = 0;
  logic s_ready, fifo_wen, fifo_ren, fifo_clr, win_valid, busy, done, cfg_err;
  logic [4:0] win_row, win_col;
  logic [15:0] perf_stall;
  convo_window_sched #(.ADDR_BIT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .img_rows(img_rows), .stride(stride),
    .s_valid(s_valid), .s_ready(s_ready), .fifo_wen(fifo_wen), .fifo_ren(fifo_ren), .fifo_clr(fifo_clr),
    .fifo_load_done(fifo_load_done), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done), .cfg_err(cfg_err), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int mode = 0, cyc = 0;
  int phase = 0, writes = 0, m_total = 0, hs = 0, m_perf = 0;
  logic m_cfg_err = 0;
  logic [9:0] wq[$];
  function automatic void check(string n, int a, int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endfunction
  // Background environment: random FIFO status, pixel stream and downstream readiness.
  initial forever begin
    @(posedge clk); #1;
    s_valid        = ($urandom % 4) != 0;
    fifo_full      = ($urandom % 5) == 0;
    fifo_empty     = ($urandom % 4) == 0;
    fifo_load_done = ($urandom % 6) == 0;
    win_ready      = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'(($urandom % 2));
    cyc++;
  end
  // Monitor: phase 0 idle, 1 loading, 2 running, 3 frame end.
  always @(negedge clk) begin
    if (rst) begin
      phase = 0; wq.delete(); m_cfg_err = 0; m_perf = 0; writes = 0;
    end else begin
      automatic logic exp_ready = (phase == 1 || phase == 2) && !fifo_full && writes < m_total;
      automatic logic exp_valid = phase == 2 && !fifo_empty;
      automatic int inc = 0;
      check("busy", busy, phase != 0);
      check("done", done, phase == 3);
      check("fifo_clr", fifo_clr, phase == 3);
      check("s_ready", s_ready, exp_ready);
      check("fifo_wen", fifo_wen, s_valid && exp_ready);
      check("win_valid", win_valid, exp_valid);
      check("fifo_ren", fifo_ren, exp_valid && win_ready);
      check("cfg_err", cfg_err, m_cfg_err);
      check("perf_stall", perf_stall, m_perf);
      if (exp_valid) begin
        if (wq.size() == 0) check("win_extra", 1, 0);
        else begin
          check("win_row", win_row, wq[0][9:5]);
          check("win_col", win_col, wq[0][4:0]);
        end
      end
      if (phase == 3) check("windows_drained", wq.size(), 0);
`ifdef CONVO_SCHED_PERF_EN
      inc = int'(phase == 2 && win_ready && fifo_empty) + int'((phase == 1 || phase == 2) && s_valid && !exp_ready);
`endif
      m_perf = (m_perf + inc > 65535) ? 65535 : m_perf + inc;
      if (s_valid && exp_ready) writes++;
      case (phase)
        0: if (start) begin
          m_cfg_err = row_len < 3 || img_rows < 3;
          m_total = int'(row_len) * int'(img_rows);
          writes = 0; m_perf = 0; hs = 0;
          phase = m_cfg_err ? 3 : 1;
        end
        1: if (fifo_load_done) phase = 2;
        2: if (exp_valid && win_ready && wq.size() > 0) begin
          void'(wq.pop_front());
          hs++;
          if (wq.size() == 0) phase = 3;
        end
        default: phase = 0;
      endcase
    end
  end
  task automatic run_frame(input int rl, input int rows, input int st, input int md, input int abort);
    automatic int s = (st == 0) ? 1 : st;
    automatic bit bad = rl < 3 || rows < 3;
    automatic bit got = 0;
    mode = md;
    row_len = 5'(rl); img_rows = 5'(rows); stride = 3'(st);
    if (!bad)
      for (int r = 0; r + 3 <= rows; r += s)
        for (int c = 0; c + 3 <= rl; c += s) wq.push_back({5'(r), 5'(c)});
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    row_len = 5'($urandom); img_rows = 5'($urandom); stride = 3'($urandom);
    if (!bad) begin
      @(posedge clk); #1; start = 1;
      @(posedge clk); #1; start = 0;
    end
    if (abort > 0) begin
      repeat (abort) @(posedge clk);
      #1; rst = 1;
      @(posedge clk); #1; rst = 0;
      return;
    end
    for (int n = 0; n < 20000 && !got; n++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      miscompares++;
      $display("FAIL frame_timeout: got no done expected done for %0dx%0d stride %0d", rl, rows, st);
      #1; rst = 1;
      @(posedge clk); #1; rst = 0;
      return;
    end
    @(posedge clk); #1;
    check("window_count", hs, bad ? 0 : ((rl - 3) / s + 1) * ((rows - 3) / s + 1));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1; rst = 0;
    @(negedge clk);
    check("reset_win_row", win_row, 0);
    check("reset_win_col", win_col, 0);
    run_frame(8, 8, 1, 0, 0);
    run_frame(8, 8, 2, 0, 0);
    run_frame(8, 8, 0, 0, 0);
    run_frame(2, 8, 1, 0, 0);
    run_frame(8, 2, 3, 0, 0);
    run_frame(8, 8, 1, 1, 0);
    run_frame(8, 8, 1, 0, 30);
    run_frame(8, 8, 1, 0, 0);
    run_frame(31, 31, 1, 0, 0);
    run_frame(5, 9, 7, 2, 0);
    run_frame(3, 3, 4, 2, 0);
    for (int i = 0; i < 15; i++)
      run_frame(int'($urandom_range(20, 2)), int'($urandom_range(20, 2)), int'($urandom % 8), int'($urandom % 3), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
